// File: rtl/tick_period_scheduler.sv
// Tick period scheduler: steps a free-running counter through up to four
// {period, tick count} entries, waiting for the counter to settle after each
// period load and counting settled ticks before advancing to the next entry.
//
// state  | meaning
// IDLE   | waiting for start, counter disabled
// LOAD   | drive period of current entry, enable counter, clear counters
// SETTLE | wait for stable, bounded by TIMEOUT cycles
// RUN    | count stable ticks until the entry count is reached
// DONE   | one-cycle completion pulse, counter disabled
module tick_period_scheduler #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       cfg_we_i,
  input  logic [1:0] cfg_addr_i,
  input  logic [7:0] cfg_period_i,
  input  logic [7:0] cfg_count_i,
  input  logic [1:0] num_steps_i,
  input  logic       loop_i,
  input  logic       stable_i,
  input  logic       tick_i,
  output logic [7:0] max_cnt_o,
  output logic       cnt_enable_o,
  output logic [1:0] step_idx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  // Timeout counter only needs to reach TIMEOUT-1: the last SETTLE cycle.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [7:0]    max_q, max_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    tk_q, tk_d;
  logic [7:0]    period_q [4];
  logic [7:0]    count_q  [4];
  logic          step_end;

  // Step ends once the counted ticks match the entry count (count 0 ends at once).
  assign step_end = (tk_q == count_q[step_q]);

  // Configuration table, writable in any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        period_q[i] <= 8'd0;
        count_q[i]  <= 8'd0;
      end
    end else if (cfg_we_i) begin
      period_q[cfg_addr_i] <= cfg_period_i;
      count_q[cfg_addr_i]  <= cfg_count_i;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      max_q   <= 8'd0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
      tk_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      max_q   <= max_d;
      en_q    <= en_d;
      err_q   <= err_d;
      to_q    <= to_d;
      tk_q    <= tk_d;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    max_d   = max_q;
    en_d    = en_q;
    err_d   = err_q;
    to_d    = to_q;
    tk_d    = tk_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_LOAD;
          step_d  = 2'd0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        max_d   = period_q[step_q];
        en_d    = 1'b1;
        to_d    = '0;
        tk_d    = 8'd0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (stable_i) begin
          state_d = S_RUN;
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          en_d    = 1'b0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_RUN: begin
        if (step_end) begin
          // A step index above a freshly lowered num_steps is treated as last.
          if (step_q >= num_steps_i) begin
            if (loop_i) begin
              step_d  = 2'd0;
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
              en_d    = 1'b0;
            end
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_LOAD;
          end
        end else if (tick_i && stable_i) begin
          tk_d = tk_q + 8'd1;
        end
      end
      S_DONE: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
    end
  end

  assign max_cnt_o    = max_q;
  assign cnt_enable_o = en_q;
  assign step_idx_o   = step_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_tick_period_scheduler.sv
// Directed bench for tick_period_scheduler with a scoreboard of expected
// loads, latencies and step sequences.
module tb_tick_period_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       cfg_we_i = 1'b0;
  logic [1:0] cfg_addr_i = 2'd0;
  logic [7:0] cfg_period_i = 8'd0;
  logic [7:0] cfg_count_i = 8'd0;
  logic [1:0] num_steps_i = 2'd0;
  logic       loop_i = 1'b0;
  logic       stable_i = 1'b0;
  logic       tick_i = 1'b0;
  logic [7:0] max_cnt_o;
  logic       cnt_enable_o;
  logic [1:0] step_idx_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  tick_period_scheduler #(.TIMEOUT(1023)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_period_i(cfg_period_i),
    .cfg_count_i(cfg_count_i), .num_steps_i(num_steps_i), .loop_i(loop_i),
    .stable_i(stable_i), .tick_i(tick_i), .max_cnt_o(max_cnt_o),
    .cnt_enable_o(cnt_enable_o), .step_idx_o(step_idx_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb[$];

  // Count done pulses away from the active edge.
  always @(negedge clk_i) if (rst_ni && done_o) done_cnt++;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_empty: observed %0d expected no output", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic cfg_write(input int a, input int p, input int c);
    cfg_we_i = 1'b1;
    cfg_addr_i = a[1:0];
    cfg_period_i = p[7:0];
    cfg_count_i = c[7:0];
    cyc();
    cfg_we_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic send_tick();
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    for (int i = 0; i < 20 && !cnt_enable_o; i++) cyc();
    chk({tag, "_en"}, cnt_enable_o, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done_o && n < 50);
  endtask

  task automatic wait_step(input int s, input string tag);
    for (int i = 0; i < 40 && step_idx_o != s[1:0]; i++) cyc();
    chk(tag, step_idx_o, s);
  endtask

  initial begin
    int n;
    logic [1:0] prev;

    // Reset state
    #3;
    chk("rst_max", max_cnt_o, 0);
    chk("rst_en", cnt_enable_o, 0);
    chk("rst_step", step_idx_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    #9 rst_ni = 1'b1;
    cyc();

    // Single step, three ticks, stable rises a few cycles after load
    cfg_write(0, 27, 3);
    num_steps_i = 2'd0;
    loop_i = 1'b0;
    stable_i = 1'b0;
    push("t1_max", 27);
    push("t1_step", 0);
    push("t1_done_lat", 1);
    pulse_start();
    wait_en("t1");
    pop_chk(max_cnt_o);
    pop_chk(step_idx_o);
    chk("t1_busy", busy_o, 1);
    cyc(); cyc(); cyc();
    stable_i = 1'b1;
    cyc();
    send_tick(); cyc();
    send_tick(); cyc(); cyc();
    chk("t1_not_early", busy_o, 1);
    send_tick();
    wait_done(n);
    pop_chk(n);
    chk("t1_done_en", cnt_enable_o, 0);
    cyc();
    chk("t1_busy_after", busy_o, 0);
    chk("t1_done_pulse", done_o, 0);
    chk("t1_done_cnt", done_cnt, 1);

    // Two steps, periods 27 then 28, write to active entry does not disturb
    cfg_write(0, 27, 2);
    cfg_write(1, 28, 2);
    num_steps_i = 2'd1;
    push("t2_max0", 27);
    push("t2_step0", 0);
    pulse_start();
    wait_en("t2");
    pop_chk(max_cnt_o);
    pop_chk(step_idx_o);
    cyc();
    send_tick();
    send_tick();
    wait_step(1, "t2_step1");
    push("t2_max1", 28);
    push("t2_step1b", 1);
    cyc();
    pop_chk(max_cnt_o);
    pop_chk(step_idx_o);
    cyc();
    cfg_write(1, 99, 2);
    chk("t2_hold_max", max_cnt_o, 28);
    push("t2_done_lat", 1);
    send_tick();
    send_tick();
    wait_done(n);
    pop_chk(n);
    cyc();
    chk("t2_done_cnt", done_cnt, 2);

    // Settle timeout
    stable_i = 1'b0;
    num_steps_i = 2'd0;
    push("t3_settle", 1023);
    pulse_start();
    wait_en("t3");
    n = 0;
    while (busy_o && n < 1100) begin
      cyc();
      n++;
    end
    pop_chk(n);
    chk("t3_err", err_o, 1);
    chk("t3_en", cnt_enable_o, 0);
    cyc();
    chk("t3_no_done", done_cnt, 2);
    stable_i = 1'b1;
    pulse_start();
    chk("t3_err_clr", err_o, 0);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("t3_abort_idle", busy_o, 0);

    // Looping sequence, then abort in RUN
    cfg_write(0, 10, 1);
    cfg_write(1, 11, 1);
    num_steps_i = 2'd1;
    loop_i = 1'b1;
    stable_i = 1'b1;
    push("t4_seq", 0);
    push("t4_seq", 1);
    push("t4_seq", 0);
    push("t4_seq", 1);
    push("t4_seq", 0);
    tick_i = 1'b1;
    pulse_start();
    tick_i = 1'b1;
    pop_chk(step_idx_o);
    prev = step_idx_o;
    for (int i = 0; i < 60 && sb.size() > 0; i++) begin
      cyc();
      if (step_idx_o != prev) begin
        pop_chk(step_idx_o);
        prev = step_idx_o;
      end
    end
    chk("t4_seq_left", sb.size(), 0);
    tick_i = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("t4_run_busy", busy_o, 1);
    chk("t4_run_en", cnt_enable_o, 1);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("t4_abort_busy", busy_o, 0);
    chk("t4_abort_en", cnt_enable_o, 0);
    loop_i = 1'b0;
    cyc(); cyc();
    chk("t4_no_done", done_cnt, 2);

    // Ticks in SETTLE and with stable low are ignored; count 0 step
    cfg_write(0, 40, 2);
    cfg_write(1, 41, 0);
    num_steps_i = 2'd1;
    stable_i = 1'b0;
    tick_i = 1'b0;
    pulse_start();
    wait_en("t5");
    tick_i = 1'b1;
    cyc(); cyc(); cyc();
    tick_i = 1'b0;
    stable_i = 1'b1;
    cyc();
    stable_i = 1'b0;
    tick_i = 1'b1;
    cyc(); cyc(); cyc();
    tick_i = 1'b0;
    stable_i = 1'b1;
    cyc(); cyc();
    chk("t5_no_count_step", step_idx_o, 0);
    chk("t5_no_count_busy", busy_o, 1);
    send_tick();
    cyc();
    chk("t5_one_tick", step_idx_o, 0);
    send_tick();
    wait_step(1, "t5_step1");
    push("t5_zero_lat", 3);
    wait_done(n);
    pop_chk(n);
    chk("t5_max", max_cnt_o, 41);
    cyc();
    chk("t5_done_cnt", done_cnt, 3);

    // Async reset mid-RUN clears outputs and table
    cfg_write(0, 50, 5);
    num_steps_i = 2'd0;
    stable_i = 1'b1;
    pulse_start();
    wait_en("t6");
    cyc();
    send_tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_max", max_cnt_o, 0);
    chk("t6_rst_en", cnt_enable_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    #1 rst_ni = 1'b1;
    cyc(); cyc();
    chk("t6_no_resume", busy_o, 0);
    push("t6_zero_lat", 2);
    pulse_start();
    wait_en("t6b");
    chk("t6_tbl_clr", max_cnt_o, 0);
    wait_done(n);
    pop_chk(n);
    cyc();
    chk("t6_done_cnt", done_cnt, 4);

    // Start while busy is ignored; start with abort in IDLE stays idle
    cfg_write(0, 60, 2);
    pulse_start();
    wait_en("t7");
    cyc();
    send_tick();
    pulse_start();
    chk("t7_ign_step", step_idx_o, 0);
    chk("t7_ign_max", max_cnt_o, 60);
    push("t7_done_lat", 1);
    send_tick();
    wait_done(n);
    pop_chk(n);
    cyc();
    start_i = 1'b1;
    abort_i = 1'b1;
    cyc();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("t7_abort_wins", busy_o, 0);
    cyc();
    chk("t7_done_cnt", done_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_period_scheduler.md
TICK_PERIOD_SCHEDULER -- requirements
Module: tick_period_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum SETTLE cycles to wait for stable before error.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 start  input  1  one-cycle request to run the programmed step sequence.
REQ-005 abort  input  1  terminates any active sequence.
REQ-006 cfg_we  input  1  table write strobe.
REQ-007 cfg_addr  input  2  table entry index 0..3.
REQ-008 cfg_period  input  8  period written to entry.
REQ-009 cfg_count  input  8  tick count written to entry.
REQ-010 num_steps  input  2  last step index; sequence runs entries 0..num_steps.
REQ-011 loop  input  1  1 = restart at entry 0 after last step instead of finishing.
REQ-012 stable  input  1  counter settled indication from free_running_stable.
REQ-013 tick  input  1  tick pulse from free_running_stable.
REQ-014 max_cnt  output  8  registered period driven to counter.
REQ-015 cnt_enable  output  1  registered enable driven to counter.
REQ-016 step_idx  output  2  current table entry.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on normal sequence completion.
REQ-019 err  output  1  sticky settle-timeout flag.

Function
REQ-020 Table: 4 entries of {period[7:0], count[7:0]}; cfg_we writes entry cfg_addr on clock edge, in any state.
REQ-021 States: IDLE, LOAD, SETTLE, RUN, DONE.
REQ-022 IDLE: cnt_enable=0; start=1 -> LOAD, step_idx=0, err cleared.
REQ-023 LOAD (one cycle): max_cnt <= table[step_idx].period, cnt_enable <= 1, timeout and tick counters cleared; -> SETTLE.
REQ-024 Table write to the active entry after its LOAD does not change max_cnt until that entry is loaded again.
REQ-025 SETTLE: stable=1 -> RUN; timeout counter reaching TIMEOUT with stable=0 -> IDLE, err=1, cnt_enable=0.
REQ-026 RUN: tick counter increments on cycles with tick=1 and stable=1; ticks in LOAD/SETTLE are not counted.
REQ-027 RUN step end: tick counter equals entry count (count 0 ends step on first RUN cycle).
REQ-028 Step end with step_idx<num_steps -> step_idx+1, LOAD.
REQ-029 Step end with step_idx==num_steps: loop=1 -> step_idx=0, LOAD; loop=0 -> DONE.
REQ-030 DONE (one cycle): done=1, cnt_enable=0; -> IDLE.
REQ-031 abort=1 in LOAD/SETTLE/RUN/DONE -> IDLE next edge, cnt_enable=0, done not pulsed; abort has priority over all transitions.
REQ-032 start while busy is ignored; start and abort together in IDLE: abort wins, stays IDLE.
REQ-033 Tick counter 8 bits, no wrap: holds at count once reached; step_idx increments modulo 4 never exceeds num_steps.
REQ-034 num_steps and loop sampled at each step end, not latched at start.

Reset
REQ-035 reset low: state IDLE; max_cnt=0, cnt_enable=0, step_idx=0, busy=0, done=0, err=0; all table entries {0,0}.
REQ-036 reset asserted mid-sequence aborts immediately with no done pulse; operation resumes only on a new start after release.

Verification
REQ-037 Table e0={27,3}, num_steps=0, loop=0, start; stable rises 4 cycles after LOAD -> max_cnt=27, 3 counted ticks, done pulse one cycle, cnt_enable=0, busy=0.
REQ-038 e0={27,2}, e1={28,2}, num_steps=1 -> max_cnt 27 then 28, step_idx 0 then 1, single done after 4th counted tick.
REQ-039 stable held 0 after start, TIMEOUT=1023 -> IDLE after 1023 SETTLE cycles, err=1, no done; next start clears err.
REQ-040 loop=1, num_steps=1 -> step_idx sequence 0,1,0,1..., no done; abort mid-RUN -> IDLE next cycle, cnt_enable=0, no done.
REQ-041 Ticks injected during SETTLE and with stable=0 in RUN -> not counted; count=0 entry -> step ends on first RUN cycle.
REQ-042 reset pulsed low during RUN -> all outputs 0 asynchronously, table cleared; start with ignored-while-busy check after re-run.
